// File: rtl/nn_sched_pkg.sv
// nn_sched_pkg: shared types and helpers for the smooth-gradient channel scheduler.
package nn_sched_pkg;

  localparam int NCH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  // One-hot decode of a channel index.
  function automatic logic [NCH-1:0] onehot4(input logic [1:0] idx);
    logic [NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/nn_rr_arbiter_4.sv
// nn_rr_arbiter_4: combinational 4-way round-robin pick. The first eligible
// request (req & ~mask) after ptr wins; ptr itself has the lowest priority.
// Instantiated only when SCHED_SKIP_IDLE_EN is defined.
module nn_rr_arbiter_4
  import nn_sched_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] mask,
  input  logic [1:0]     ptr,
  output logic           gnt_valid,
  output logic [1:0]     gnt_idx
);

  logic [NCH-1:0] elig;
  logic [1:0]     cand;

  assign elig = req & ~mask;

  // Scan from farthest to nearest so the channel right after ptr wins last.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = NCH; i >= 1; i--) begin
      cand = ptr + 2'(i);
      if (elig[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/nn_smoothgrad_channel_scheduler.sv
// nn_smoothgrad_channel_scheduler: sequences the shared 4-channel polar
// smooth-gradient accumulator. Issues at most one registered grant per RUN
// cycle, bounds each epoch to N_EPOCH RUN cycles and counts grants.
// Build option SCHED_SKIP_IDLE_EN: work-conserving round-robin arbitration;
// when undefined, a fixed TDM sweep 0,1,2,3,... is used.
module nn_smoothgrad_channel_scheduler
  import nn_sched_pkg::*;
#(
  parameter int N_EPOCH = 1024,
  parameter int N_CNT   = 11
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             CLK_TRAINING_flag,
  input  logic [3:0]       REQ,
  input  logic [3:0]       IN_SS,
  input  logic [3:0]       SIGN,
  output logic [3:0]       GRANT,
  output logic [1:0]       regIndex,
  output logic             EN,
  output logic [3:0]       SS_Q,
  output logic [3:0]       SIGN_Q,
  output logic             EPOCH_DONE,
  output logic [N_CNT-1:0] UPD_CNT
);

  localparam logic [N_CNT-1:0] LAST_EPOCH = N_CNT'(N_EPOCH - 1);
  localparam logic [N_CNT-1:0] CNT_MAX    = '1;

  sched_state_t     state, nextState;
  logic [N_CNT-1:0] epochCnt, nextEpoch;
  logic             runNext, enterRun, winValid, doGrant;
  logic [1:0]       winIdx;
  logic [NCH-1:0]   winVec;

  // Next-state decode; epoch end takes priority over a dropped training flag.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (CLK_TRAINING_flag) nextState = RUN;
      RUN: begin
        if (epochCnt == LAST_EPOCH)   nextState = HOLD;
        else if (!CLK_TRAINING_flag)  nextState = IDLE;
      end
      HOLD:    if (!CLK_TRAINING_flag) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Decisions are taken at the edge that starts a RUN cycle, so every
  // registered output describes the cycle it is visible in.
  assign runNext   = (nextState == RUN);
  assign enterRun  = (state == IDLE) && runNext;
  assign nextEpoch = enterRun ? '0 : epochCnt + N_CNT'(1);

`ifdef SCHED_SKIP_IDLE_EN
  logic [1:0] rrPtr;

  // Last cycle's grant is masked so a requester that has not yet dropped
  // REQ cannot be granted twice for the same bit.
  nn_rr_arbiter_4 uArb (
    .req       (REQ),
    .mask      (GRANT),
    .ptr       (rrPtr),
    .gnt_valid (winValid),
    .gnt_idx   (winIdx)
  );

  // Round-robin pointer follows the most recent winner; starts at 3 so ch0 wins first.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT)         rrPtr <= 2'd3;
    else if (doGrant) rrPtr <= winIdx;
  end
`else
  logic [1:0] slot, nextSlot;

  assign nextSlot = enterRun ? 2'd0 : slot + 2'd1;
  assign winIdx   = nextSlot;
  assign winValid = REQ[nextSlot];

  // TDM slot of the current RUN cycle; consecutive slots never repeat a channel.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT)         slot <= 2'd0;
    else if (runNext) slot <= nextSlot;
  end
`endif

  assign doGrant = runNext && winValid;
  assign winVec  = onehot4(winIdx);

  // FSM state register.
  always_ff @(posedge CLK or posedge INIT) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (INIT) state <= IDLE;
    else      state <= nextState;
  end

  // Accumulator-facing outputs, epoch counter and grant counter, all aligned to the same edge.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      GRANT      <= '0;
      regIndex   <= 2'd0;
      EN         <= 1'b0;
      SS_Q       <= '0;
      SIGN_Q     <= '0;
      EPOCH_DONE <= 1'b0;
      UPD_CNT    <= '0;
      epochCnt   <= '0;
    end else begin
      GRANT      <= doGrant ? winVec : '0;
      EN         <= doGrant;
      SS_Q       <= doGrant ? (IN_SS & winVec) : '0;
      SIGN_Q     <= doGrant ? (SIGN & winVec) : '0;
      EPOCH_DONE <= runNext && (nextEpoch == LAST_EPOCH);
      if (doGrant) regIndex <= winIdx;
      if (runNext) epochCnt <= nextEpoch;
      if (enterRun)
        UPD_CNT <= doGrant ? N_CNT'(1) : '0;
      else if (doGrant && (UPD_CNT != CNT_MAX))
        UPD_CNT <= UPD_CNT + N_CNT'(1);
    end
  end

endmodule

// File: tb/tb_nn_smoothgrad_channel_scheduler.sv
// tb_nn_smoothgrad_channel_scheduler: table-driven, hand-written and random
// checks of the scheduler against an epoch-level reference model.
// Follows SCHED_SKIP_IDLE_EN the same way the design does.
module tb_nn_smoothgrad_channel_scheduler;

  localparam int N_EPOCH = 8;
  localparam int N_CNT   = 4;

  logic             CLK = 1'b0;
  logic             INIT;
  logic             flag;
  logic [3:0]       REQ, IN_SS, SIGN;
  logic [3:0]       GRANT;
  logic [1:0]       regIndex;
  logic             EN;
  logic [3:0]       SS_Q, SIGN_Q;
  logic             EPOCH_DONE;
  logic [N_CNT-1:0] UPD_CNT;

  int errors = 0;
  int checks = 0;

  nn_smoothgrad_channel_scheduler #(.N_EPOCH(N_EPOCH), .N_CNT(N_CNT)) dut (
    .CLK               (CLK),
    .INIT              (INIT),
    .CLK_TRAINING_flag (flag),
    .REQ               (REQ),
    .IN_SS             (IN_SS),
    .SIGN              (SIGN),
    .GRANT             (GRANT),
    .regIndex          (regIndex),
    .EN                (EN),
    .SS_Q              (SS_Q),
    .SIGN_Q            (SIGN_Q),
    .EPOCH_DONE        (EPOCH_DONE),
    .UPD_CNT           (UPD_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]       grant;
    logic [1:0]       idx;
    logic             en;
    logic [3:0]       ss;
    logic [3:0]       sg;
    logic             done;
    logic [N_CNT-1:0] cnt;
  } outs_t;

  typedef struct {
    logic       flag;
    logic [3:0] req;
    logic [3:0] ss;
    logic [3:0] sg;
    outs_t      exp;
  } vec_t;

  vec_t tbl[$];

  // ---------------- reference model ----------------
  // Phase 0 = idle, 1 = running an epoch (mK = RUN cycle index), 2 = epoch finished.
  int    mPhase;
  int    mK;
  int    mPtr;
  outs_t mOut;

  function automatic outs_t zero_outs();
    outs_t o;
    o.grant = '0; o.idx = '0; o.en = 1'b0; o.ss = '0; o.sg = '0; o.done = 1'b0; o.cnt = '0;
    return o;
  endfunction

  task automatic model_reset();
    mPhase = 0;
    mK     = 0;
    mPtr   = 3;
    mOut   = zero_outs();
  endtask

  // Expected outputs for the cycle that starts at the edge sampling these inputs.
  task automatic model_edge(input logic f, input logic [3:0] r, input logic [3:0] s, input logic [3:0] g);
    logic [3:0] prev;
    bit         entering;
    int         w;
    int         c;
    prev     = mOut.grant;
    entering = 0;
    case (mPhase)
      0: if (f) begin mPhase = 1; mK = 0; entering = 1; end
      1: begin
        if (mK == N_EPOCH - 1) mPhase = 2;
        else if (!f)           mPhase = 0;
        else                   mK = mK + 1;
      end
      default: if (!f) mPhase = 0;
    endcase
    mOut.grant = '0; mOut.en = 1'b0; mOut.ss = '0; mOut.sg = '0; mOut.done = 1'b0;
    if (mPhase == 1) begin
      if (entering) mOut.cnt = '0;
      w = -1;
`ifdef SCHED_SKIP_IDLE_EN
      for (int d = 1; d <= 4; d++) begin
        c = (mPtr + d) % 4;
        if (w < 0 && r[c] && !prev[c]) w = c;
      end
`else
      c = mK % 4;
      if (r[c]) w = c;
`endif
      if (w >= 0) begin
        mOut.grant = 4'(1 << w);
        mOut.en    = 1'b1;
        mOut.idx   = 2'(w);
        mOut.ss    = s & mOut.grant;
        mOut.sg    = g & mOut.grant;
        if (mOut.cnt != {N_CNT{1'b1}}) mOut.cnt = mOut.cnt + 1'b1;
        mPtr = w;
      end
      mOut.done = (mK == N_EPOCH - 1);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input outs_t e);
    check({tag, ".GRANT"},      32'(GRANT),      32'(e.grant));
    check({tag, ".regIndex"},   32'(regIndex),   32'(e.idx));
    check({tag, ".EN"},         32'(EN),         32'(e.en));
    check({tag, ".SS_Q"},       32'(SS_Q),       32'(e.ss));
    check({tag, ".SIGN_Q"},     32'(SIGN_Q),     32'(e.sg));
    check({tag, ".EPOCH_DONE"}, 32'(EPOCH_DONE), 32'(e.done));
    check({tag, ".UPD_CNT"},    32'(UPD_CNT),    32'(e.cnt));
  endtask

  // Called at a negedge: drive, let the DUT and model take the edge, return at the next negedge.
  task automatic step(input logic f, input logic [3:0] r, input logic [3:0] s, input logic [3:0] g);
    flag = f; REQ = r; IN_SS = s; SIGN = g;
    @(posedge CLK);
    model_edge(f, r, s, g);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    INIT = 1'b1; flag = 1'b0; REQ = '0; IN_SS = '0; SIGN = '0;
    #1;
    model_reset();
    check_outs("reset", mOut);
    @(negedge CLK);
    INIT = 1'b0;
  endtask

  task automatic add(input logic f, input logic [3:0] r, input logic [3:0] s, input logic [3:0] g,
                     input logic [3:0] eg, input logic [1:0] ei, input logic ee, input logic [3:0] es,
                     input logic [3:0] esg, input logic ed, input logic [N_CNT-1:0] ec);
    vec_t v;
    v.flag = f; v.req = r; v.ss = s; v.sg = g;
    v.exp.grant = eg; v.exp.idx = ei; v.exp.en = ee; v.exp.ss = es;
    v.exp.sg = esg; v.exp.done = ed; v.exp.cnt = ec;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].flag, tbl[i].req, tbl[i].ss, tbl[i].sg);
      check_outs($sformatf("%s[%0d]", tag, i), tbl[i].exp);
    end
    tbl.delete();
  endtask

  // ---------------- test sequence ----------------
  logic [3:0] reqV, ssV, sgV, gPrev, gNow;
  logic       flagV;

  initial begin
    INIT = 1'b1; flag = 1'b0; REQ = '0; IN_SS = '0; SIGN = '0;
    model_reset();
    @(negedge CLK);

    // All channels requesting: round-robin and TDM both give 1,2,4,8,...; epoch of 8, then HOLD, then IDLE.
    add(1, 4'hF, 4'hA, 4'h5, 4'b0001, 2'd0, 1, 4'b0000, 4'b0001, 0, 4'd1);
    add(1, 4'hF, 4'hA, 4'h5, 4'b0010, 2'd1, 1, 4'b0010, 4'b0000, 0, 4'd2);
    add(1, 4'hF, 4'hA, 4'h5, 4'b0100, 2'd2, 1, 4'b0000, 4'b0100, 0, 4'd3);
    add(1, 4'hF, 4'hA, 4'h5, 4'b1000, 2'd3, 1, 4'b1000, 4'b0000, 0, 4'd4);
    add(1, 4'hF, 4'hA, 4'h5, 4'b0001, 2'd0, 1, 4'b0000, 4'b0001, 0, 4'd5);
    add(1, 4'hF, 4'hA, 4'h5, 4'b0010, 2'd1, 1, 4'b0010, 4'b0000, 0, 4'd6);
    add(1, 4'hF, 4'hA, 4'h5, 4'b0100, 2'd2, 1, 4'b0000, 4'b0100, 0, 4'd7);
    add(1, 4'hF, 4'hA, 4'h5, 4'b1000, 2'd3, 1, 4'b1000, 4'b0000, 1, 4'd8);
    add(1, 4'hF, 4'hA, 4'h5, 4'b0000, 2'd3, 0, 4'b0000, 4'b0000, 0, 4'd8);
    add(0, 4'hF, 4'hA, 4'h5, 4'b0000, 2'd3, 0, 4'b0000, 4'b0000, 0, 4'd8);
    add(0, 4'hF, 4'hA, 4'h5, 4'b0000, 2'd3, 0, 4'b0000, 4'b0000, 0, 4'd8);
    run_table("all_req");

`ifdef SCHED_SKIP_IDLE_EN
    // Single permanent requester: granted every other cycle.
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 4'b0100, 4'b0000, 0, 4'd1);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 2'd2, 0, 4'b0000, 4'b0000, 0, 4'd1);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 4'b0100, 4'b0000, 0, 4'd2);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 2'd2, 0, 4'b0000, 4'b0000, 0, 4'd2);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 4'b0100, 4'b0000, 0, 4'd3);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 2'd2, 0, 4'b0000, 4'b0000, 0, 4'd3);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 4'b0100, 4'b0000, 0, 4'd4);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 2'd2, 0, 4'b0000, 4'b0000, 1, 4'd4);
    add(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 2'd2, 0, 4'b0000, 4'b0000, 0, 4'd4);
    add(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 2'd2, 0, 4'b0000, 4'b0000, 0, 4'd4);
    run_table("single_req");
`else
    // Only channel 1 requesting: served on slot 1 of each sweep (RUN cycles 1 and 5).
    add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000, 4'b0000, 0, 4'd0);
    add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 4'b0010, 4'b0000, 0, 4'd1);
    add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 0, 4'd1);
    add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 0, 4'd1);
    add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 0, 4'd1);
    add(1, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1, 4'b0000, 4'b0010, 0, 4'd2);
    add(1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 0, 4'd2);
    add(1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 1, 4'd2);
    add(1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 0, 4'd2);
    add(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 2'd1, 0, 4'b0000, 4'b0000, 0, 4'd2);
    run_table("tdm_ch1");
`endif

    // INIT pulse in the middle of a RUN cycle clears outputs immediately; ch0 wins first afterwards.
    do_reset();
    repeat (3) begin
      step(1, 4'hF, 4'hF, 4'hF);
      check_outs("pre_init", mOut);
    end
    #2 INIT = 1'b1;
    #1;
    check("init.GRANT", 32'(GRANT), 32'd0);
    check("init.EN", 32'(EN), 32'd0);
    check("init.regIndex", 32'(regIndex), 32'd0);
    check("init.SS_Q", 32'(SS_Q), 32'd0);
    check("init.SIGN_Q", 32'(SIGN_Q), 32'd0);
    check("init.UPD_CNT", 32'(UPD_CNT), 32'd0);
    @(negedge CLK);
    INIT = 1'b0;
    model_reset();
    step(1, 4'hF, 4'h1, 4'h0);
    check("init.first_grant", 32'(GRANT), 32'h1);
    check("init.first_cnt", 32'(UPD_CNT), 32'd1);
    check_outs("post_init", mOut);

    // Training flag dropped in RUN cycle 3: EN stops next cycle, count kept, re-raise clears it.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 4'hF, 4'h3, 4'hC);
      check($sformatf("abort.run%0d.EN", k), 32'(EN), 32'd1);
    end
    step(0, 4'hF, 4'h3, 4'hC);
    check("abort.EN", 32'(EN), 32'd0);
    check("abort.GRANT", 32'(GRANT), 32'd0);
    check("abort.DONE", 32'(EPOCH_DONE), 32'd0);
    check("abort.UPD_CNT", 32'(UPD_CNT), 32'd4);
    step(0, 4'hF, 4'h3, 4'hC);
    check("abort.idle_cnt", 32'(UPD_CNT), 32'd4);
    step(1, 4'hF, 4'h3, 4'hC);
    check("abort.rerun_grant", 32'(GRANT), 32'h1);
    check("abort.rerun_cnt", 32'(UPD_CNT), 32'd1);

    // Randomised traffic against the model; requesters hold REQ until one edge past their grant.
    do_reset();
    reqV = '0; ssV = '0; sgV = '0; gPrev = '0; flagV = 1'b1;
    for (int n = 0; n < 800; n++) begin
      step(flagV, reqV, ssV, sgV);
      check_outs("rand", mOut);
      gNow = mOut.grant;
      for (int c = 0; c < 4; c++) begin
        if (gPrev[c]) begin
          reqV[c] = 1'($urandom_range(0, 1));
          ssV[c]  = 1'($urandom_range(0, 1));
          sgV[c]  = 1'($urandom_range(0, 1));
        end else if (!reqV[c] && !gNow[c] && ($urandom_range(0, 3) == 0)) begin
          reqV[c] = 1'b1;
          ssV[c]  = 1'($urandom_range(0, 1));
          sgV[c]  = 1'($urandom_range(0, 1));
        end
      end
      gPrev = gNow;
      if ($urandom_range(0, 9) == 0) flagV = ~flagV;
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
        gPrev = '0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
